// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package muldiv_pkg;

  // Operation encoding as carried in the ID/EX register.
  // op[2] selects divide, op[1] selects unsigned divide, op[0] selects remainder.
  typedef enum logic [2:0] {
    MUL_W   = 3'b000,
    MULH_W  = 3'b001,
    MULH_WU = 3'b010,
    OP_RSV  = 3'b011,
    DIV_W   = 3'b100,
    MOD_W   = 3'b101,
    DIV_WU  = 3'b110,
    MOD_WU  = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int          DIV_ITERS_C        = 32;
  localparam logic [31:0] DIV_BY_ZERO_RESULT = 32'hFFFF_FFFF;

  // Two's-complement magnitude; 0x80000000 maps to itself, which the
  // unsigned divider then treats as +2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per step.
// load captures operands and clears the counter; each step shifts in one
// dividend bit. quotient/remainder show the value after the current step,
// so the owner can capture the final answer on the edge where last=1.
module muldiv_div_core #(
  parameter int W     = 32,
  parameter int ITERS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         last
);

  localparam int CNT_W = $clog2(ITERS);

  logic [W-1:0]     rem_reg;
  logic [W-1:0]     quo_reg;
  logic [W-1:0]     dvs_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [W:0] shifted;
  logic [W:0] diff;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  always_comb begin
    shifted   = {rem_reg, quo_reg[W-1]};
    diff      = shifted - {1'b0, dvs_reg};
    remainder = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    quotient  = {quo_reg[W-2:0], ~diff[W]};
  end

  assign last = (cnt_reg == CNT_W'(ITERS - 1));

  // Operand capture and per-step update of remainder, quotient and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dvs_reg <= divisor;
      cnt_reg <= '0;
    end else if (step) begin
      rem_reg <= remainder;
      quo_reg <= quotient;
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit.
// Multiply takes one extra cycle (result two cycles after start); divide runs
// a 32-step restoring divider. Divide by zero finishes after one cycle.
// Optional build macro MULDIV_EARLY_OUT_EN: a divide whose dividend magnitude
// is below the divisor magnitude also finishes after one cycle.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_ITERS  = DIV_ITERS_C
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  stallreq,
  output logic                  busy
);

  muldiv_state_t         state_reg;
  muldiv_op_t            op_reg;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic                  q_neg_reg;
  logic                  r_neg_reg;
  logic [DATA_WIDTH-1:0] result_reg;

  // Operand magnitudes as seen by the unsigned divider.
  logic                  div_signed;
  logic [DATA_WIDTH-1:0] src1_mag;
  logic [DATA_WIDTH-1:0] src2_mag;
  logic                  div_zero;

  assign div_signed = ~op[1];
  assign src1_mag   = div_signed ? abs32(src1) : src1;
  assign src2_mag   = div_signed ? abs32(src2) : src2;
  assign div_zero   = (src2 == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic early_lt;
  assign early_lt = (src1_mag < src2_mag);
`endif

  // Multiplier: sign- or zero-extend the latched operands to 64 bits so a
  // single product serves MUL_W, MULH_W and MULH_WU.
  logic                          mul_signed;
  logic signed [2*DATA_WIDTH-1:0] mul_a;
  logic signed [2*DATA_WIDTH-1:0] mul_b;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]          mul_sel;

  assign mul_signed = (op_reg == MULH_W);
  assign mul_a      = {{DATA_WIDTH{mul_signed & a_reg[DATA_WIDTH-1]}}, a_reg};
  assign mul_b      = {{DATA_WIDTH{mul_signed & b_reg[DATA_WIDTH-1]}}, b_reg};
  assign prod       = mul_a * mul_b;

  // Pick the half of the product the operation asks for.
  always_comb begin
    mul_sel = prod[DATA_WIDTH-1:0];
    if (op_reg == MULH_W || op_reg == MULH_WU) begin
      mul_sel = prod[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  // Divider core and sign fixup of its final step.
  logic                  core_load;
  logic                  core_step;
  logic                  core_last;
  logic [DATA_WIDTH-1:0] core_q;
  logic [DATA_WIDTH-1:0] core_r;
  logic [DATA_WIDTH-1:0] div_sel;

  assign core_load = (state_reg == IDLE) & start & op[2] & ~div_zero;
  assign core_step = (state_reg == DIV);

  muldiv_div_core #(
    .W     (DATA_WIDTH),
    .ITERS (DIV_ITERS)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst | flush),
    .load      (core_load),
    .step      (core_step),
    .dividend  (src1_mag),
    .divisor   (src2_mag),
    .quotient  (core_q),
    .remainder (core_r),
    .last      (core_last)
  );

  // Restore signs; the 0x80000000 / -1 overflow falls out naturally here.
  always_comb begin
    if (op_reg == MOD_W || op_reg == MOD_WU) begin
      div_sel = r_neg_reg ? (~core_r + 1'b1) : core_r;
    end else begin
      div_sel = q_neg_reg ? (~core_q + 1'b1) : core_q;
    end
  end

  // Control FSM: operand capture, multiply/divide completion and hand-off.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_reg  <= IDLE;
      op_reg     <= MUL_W;
      a_reg      <= '0;
      b_reg      <= '0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg <= (op == 3'b011) ? MUL_W : muldiv_op_t'(op);
            a_reg  <= src1;
            b_reg  <= src2;
            if (!op[2]) begin
              state_reg <= MUL;
            end else begin
              q_neg_reg <= div_signed & (src1[DATA_WIDTH-1] ^ src2[DATA_WIDTH-1]);
              r_neg_reg <= div_signed & src1[DATA_WIDTH-1];
              if (div_zero) begin
                result_reg <= op[0] ? src1 : DIV_BY_ZERO_RESULT;
                state_reg  <= DONE;
              end
`ifdef MULDIV_EARLY_OUT_EN
              else if (early_lt) begin
                result_reg <= op[0] ? src1 : '0;
                state_reg  <= DONE;
              end
`endif
              else begin
                state_reg <= DIV;
              end
            end
          end
        end
        MUL: begin
          result_reg <= mul_sel;
          state_reg  <= DONE;
        end
        DIV: begin
          if (core_last) begin
            result_reg <= div_sel;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          if (!hold) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign result   = result_reg;
  assign done     = (state_reg == DONE);
  assign busy     = (state_reg != IDLE);
  assign stallreq = ((state_reg == IDLE) & start & ~flush) |
                    (state_reg == MUL) | (state_reg == DIV);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed, table-driven bench for ex_muldiv plus flush/hold/reset sequences.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        hold;
  logic [31:0] result;
  logic        done;
  logic        stallreq;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .hold     (hold),
    .result   (result),
    .done     (done),
    .stallreq (stallreq),
    .busy     (busy)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          hold_cycles;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e, input int l, input int h);
    vec_t v;
    v.name = nm; v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l; v.hold_cycles = h;
    vecs.push_back(v);
  endtask

  // Issue one operation at posedge+1, count edges until done, check result,
  // optional hold window, and return to idle.
  task automatic run_vec(input vec_t v);
    int          lat;
    logic        stall_ok;
    logic [31:0] held;
    start = 1'b1; op = v.op; src1 = v.a; src2 = v.b;
    #1;
    stall_ok = stallreq;
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0; src1 = $urandom; src2 = $urandom; op = 3'($urandom);
      end
      if (done || lat >= 100) break;
      if (!stallreq) stall_ok = 1'b0;
    end
    check({v.name, "_lat"}, 32'(lat), 32'(v.lat));
    check({v.name, "_res"}, result, v.exp);
    check({v.name, "_stall"}, {31'b0, stall_ok}, 32'd1);
    held = result;
    if (v.hold_cycles > 0) begin
      hold = 1'b1;
      for (int i = 0; i < v.hold_cycles; i++) begin
        @(posedge clk); #1;
        check({v.name, "_hold_done"}, {31'b0, done}, 32'd1);
        check({v.name, "_hold_res"}, result, held);
      end
      hold = 1'b0;
    end
    @(posedge clk); #1;
    check({v.name, "_idle"}, {30'b0, busy, done}, 32'd0);
    $display("%s op=%b a=%h b=%h result=%h lat=%0d", v.name, v.op, v.a, v.b, held, lat);
  endtask

  initial begin
    logic seen_done;
    vec_t v;

    add("mul_w",      3'b000, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFA, 2,  0);
    add("mulh_w",     3'b001, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 2,  0);
    add("mulh_wu",    3'b010, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 2,  0);
    add("rsv_as_mul", 3'b011, 32'd7,         32'd6,        32'd42,        2,  0);
    add("mul_w_wrap", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0,       2,  0);
    add("mulh_wu_2",  3'b010, 32'h0001_0000, 32'h0001_0000, 32'd1,       2,  0);
    add("mulh_w_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0);
    add("div_w",      3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 0);
    add("mod_w",      3'b101, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 0);
    add("div_wu",     3'b110, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 33, 0);
    add("mod_wu",     3'b111, 32'hFFFF_FFF9, 32'd2,        32'd1,         33, 0);
    add("div_w_negb", 3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    add("mod_w_negb", 3'b101, 32'd7,         32'hFFFF_FFFE, 32'd1,        33, 0);
    add("div0_wu",    3'b110, 32'd100,       32'd0,        32'hFFFF_FFFF, 1,  0);
    add("mod0_wu",    3'b111, 32'd100,       32'd0,        32'd100,       1,  0);
    add("div0_w",     3'b100, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 1,  0);
    add("mod0_w",     3'b101, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1,  0);
    add("div_w_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
    add("mod_w_ovf",  3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        33, 0);
    add("div_wu_hold",3'b110, 32'd7,         32'd3,        32'd2,         33, 5);
    add("div_wu_lt",  3'b110, 32'd3,         32'd7,        32'd0,         EO_LAT, 0);
    add("mod_wu_lt",  3'b111, 32'd3,         32'd7,        32'd3,         EO_LAT, 0);
    add("div_w_lt",   3'b100, 32'hFFFF_FFFD, 32'd7,        32'd0,         EO_LAT, 0);
    add("mod_w_lt",   3'b101, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFD, EO_LAT, 0);

    rst = 1'b1; flush = 1'b0; start = 1'b0; hold = 1'b0;
    op = 3'b000; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {29'b0, busy, done, stallreq}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // start together with flush in IDLE: no stall, nothing launched
    start = 1'b1; flush = 1'b1; op = 3'b000; src1 = 32'd9; src2 = 32'd9;
    #1;
    check("start_flush_stall", {31'b0, stallreq}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", {31'b0, busy}, 32'd0);

    // flush mid-divide: operation discarded, no done pulse afterwards
    start = 1'b1; op = 3'b100; src1 = 32'hFFFF_FFF9; src2 = 32'd2;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_state", {29'b0, busy, done, stallreq}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done |= done;
    end
    check("flush_no_done", {31'b0, seen_done}, 32'd0);
    $display("flush_mid_div busy=%b done_seen=%b", busy, seen_done);
    v.name = "mul_after_flush"; v.op = 3'b000; v.a = 32'd5; v.b = 32'd6;
    v.exp = 32'd30; v.lat = 2; v.hold_cycles = 0;
    run_vec(v);

    // flush while holding in DONE: result lost
    start = 1'b1; op = 3'b110; src1 = 32'd100; src2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; hold = 1'b1;
    check("dz_done_before_flush", {31'b0, done}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; hold = 1'b0;
    check("flush_in_done", {29'b0, busy, done, stallreq}, 32'd0);
    check("flush_in_done_res", result, 32'd0);
    $display("flush_in_done result=%h done=%b", result, done);

    // reset mid-multiply
    start = 1'b1; op = 3'b000; src1 = 32'd3; src2 = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_mul", {29'b0, busy, done, stallreq}, 32'd0);
    $display("rst_mid_mul busy=%b done=%b", busy, done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
